pong_match_ctrl: RTL

//  Match sequencer and custom-instruction front end for the Pong display.
//  - Decodes Nios custom-instruction commands and buffers paddle positions.
//  - Applies paddle positions to both printBar instances once per frame (tear-free).
//  - Runs serve/play/point/game-over sequencing from the ball's miss events.
//  - Keeps both scores and returns a status word on result.

---
 rtl/pong_match_ctrl_pkg.sv | 47 ++++
 rtl/pong_paddle_shadow.sv | 64 ++++++
 rtl/pong_match_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_pkg.sv
// Shared types and field positions for the Pong match controller: FSM state codes,
// custom-instruction opcodes, command/status word layout and small helpers.
package pong_match_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_PADDLE = 2'b00,
        OP_STATUS = 2'b01,
        OP_START  = 2'b10,
        OP_ABORT  = 2'b11
    } op_t;

    // Command word fields
    localparam int OP_MSB      = 12;
    localparam int OP_LSB      = 11;
    localparam int BAR_SEL_BIT = 10;
    localparam int Y_MSB       = 8;

    // Status word fields
    localparam int ST_STATE_LSB  = 24;
    localparam int ST_OVER_BIT   = 16;
    localparam int ST_SCORE2_LSB = 8;
    localparam int ST_SCORE1_LSB = 0;

    function automatic logic [31:0] status_word(input state_t st, input logic over,
                                                input logic [7:0] s2, input logic [7:0] s1);
        logic [31:0] w;
        w = '0;
        w[ST_STATE_LSB +: 3]  = st;
        w[ST_OVER_BIT]        = over;
        w[ST_SCORE2_LSB +: 8] = s2;
        w[ST_SCORE1_LSB +: 8] = s1;
        return w;
    endfunction

    function automatic logic [8:0] clamp_y(input logic [8:0] y, input logic [8:0] y_max);
        return (y > y_max) ? y_max : y;
    endfunction

endpackage

// File: rtl/pong_paddle_shadow.sv
// Per-bar shadow register: clamps written y, holds it pending, and applies it to the
// visible bar position only on a frame tick so the bar never tears mid-frame.
module pong_paddle_shadow #(
    parameter logic [8:0] Y_MAX  = 9'd416,
    parameter logic [8:0] Y_INIT = 9'd208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [8:0] wr_y,
    input  logic       clr,
    input  logic       tick,
    output logic [8:0] y,
    output logic       refresh
);
    import pong_match_ctrl_pkg::*;

    logic [8:0] pending_d, pending_q;
    logic [8:0] y_d, y_q;
    logic       flag_d, flag_q;
    logic       refresh_d, refresh_q;

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        pending_d = pending_q;
        flag_d    = flag_q;
        y_d       = y_q;
        refresh_d = 1'b0;

        // The tick consumes the value pending before this cycle; a write landing on
        // the same edge re-arms the flag and waits for the next tick.
        if (tick && flag_q && !clr) begin
            y_d       = pending_q;
            refresh_d = 1'b1;
            flag_d    = 1'b0;
        end
        if (clr) begin
            flag_d = 1'b0;
        end
        if (wr_en) begin
            pending_d = clamp_y(wr_y, Y_MAX);
            flag_d    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= Y_INIT;
            flag_q    <= 1'b0;
            y_q       <= Y_INIT;
            refresh_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            flag_q    <= flag_d;
            y_q       <= y_d;
            refresh_q <= refresh_d;
        end
    end

    assign y       = y_q;
    assign refresh = refresh_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: Nios custom-instruction front end, serve/play/point/over FSM,
// score keeping, and two tear-free paddle shadow registers.
module pong_match_ctrl #(
    parameter logic [8:0] Y_MAX        = 9'd416,
    parameter logic [8:0] Y_INIT       = 9'd208,
    parameter logic [7:0] WIN_SCORE    = 8'd7,
    parameter logic [7:0] SERVE_FRAMES = 8'd60
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        CLK_EN,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    input  logic        frame_tick,
    input  logic        miss_l,
    input  logic        miss_r,
    output logic [8:0]  yBar1,
    output logic [8:0]  yBar2,
    output logic        refreshBar1,
    output logic        refreshBar2,
    output logic        ball_rst,
    output logic        ball_en,
    output logic        game_over
);
    import pong_match_ctrl_pkg::*;

    op_t         op;
    logic        cmd_write, cmd_start, cmd_abort;
    logic        wr_bar1, wr_bar2;
    logic        serve_entry;

    state_t      state_d, state_q;
    logic [7:0]  score1_d, score1_q;
    logic [7:0]  score2_d, score2_q;
    logic [7:0]  frame_cnt_d, frame_cnt_q;
    logic        ball_rst_d, ball_rst_q;
    logic        ball_en_d, ball_en_q;
    logic        game_over_d, game_over_q;
    logic        done_d, done_q;
    logic [31:0] result_d, result_q;

    logic unused_dataa;
    assign unused_dataa = ^{dataa[31:13], dataa[9]};

    always_comb begin
        op        = op_t'(dataa[OP_MSB:OP_LSB]);
        cmd_write = CLK_EN && (op == OP_PADDLE);
        cmd_start = CLK_EN && (op == OP_START);
        cmd_abort = CLK_EN && (op == OP_ABORT);
        wr_bar1   = cmd_write && !dataa[BAR_SEL_BIT];
        wr_bar2   = cmd_write &&  dataa[BAR_SEL_BIT];
    end

    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_cnt_q - 8'd1;
                    if (frame_cnt_q <= 8'd1) state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (miss_l && miss_r) begin
                    state_d = ST_SERVE;
                end else if (miss_l) begin
                    if (score2_q < WIN_SCORE) score2_d = score2_q + 8'd1;
                    state_d = ST_POINT;
                end else if (miss_r) begin
                    if (score1_q < WIN_SCORE) score1_d = score1_q + 8'd1;
                    state_d = ST_POINT;
                end
            end
            ST_POINT: begin
                state_d = (score1_q == WIN_SCORE || score2_q == WIN_SCORE) ? ST_OVER : ST_SERVE;
            end
            ST_OVER: begin
                if (cmd_start) begin
                    score1_d = 8'd0;
                    score2_d = 8'd0;
                    state_d  = ST_SERVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cmd_abort) begin
            state_d  = ST_IDLE;
            score1_d = 8'd0;
            score2_d = 8'd0;
        end

        // Every way into SERVE re-centres the ball and restarts the serve delay.
        serve_entry = (state_d == ST_SERVE) && (state_q != ST_SERVE);
        if (serve_entry) frame_cnt_d = SERVE_FRAMES;

        ball_rst_d  = serve_entry;
        ball_en_d   = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_OVER);

        // Status reflects the state before this cycle's command takes effect.
        done_d   = CLK_EN;
        result_d = CLK_EN ? status_word(state_q, game_over_q, score2_q, score1_q) : 32'd0;
    end

    always_ff @(posedge CLK) begin
        if (RST_BTN) begin
            state_q     <= ST_IDLE;
            score1_q    <= 8'd0;
            score2_q    <= 8'd0;
            frame_cnt_q <= 8'd0;
            ball_rst_q  <= 1'b0;
            ball_en_q   <= 1'b0;
            game_over_q <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            frame_cnt_q <= frame_cnt_d;
            ball_rst_q  <= ball_rst_d;
            ball_en_q   <= ball_en_d;
            game_over_q <= game_over_d;
            done_q      <= done_d;
            result_q    <= result_d;
        end
    end

    pong_paddle_shadow #(.Y_MAX(Y_MAX), .Y_INIT(Y_INIT)) u_bar1 (
        .clk     (CLK),
        .rst     (RST_BTN),
        .wr_en   (wr_bar1),
        .wr_y    (dataa[Y_MSB:0]),
        .clr     (cmd_abort),
        .tick    (frame_tick),
        .y       (yBar1),
        .refresh (refreshBar1)
    );

    pong_paddle_shadow #(.Y_MAX(Y_MAX), .Y_INIT(Y_INIT)) u_bar2 (
        .clk     (CLK),
        .rst     (RST_BTN),
        .wr_en   (wr_bar2),
        .wr_y    (dataa[Y_MSB:0]),
        .clr     (cmd_abort),
        .tick    (frame_tick),
        .y       (yBar2),
        .refresh (refreshBar2)
    );

    assign result    = result_q;
    assign done      = done_q;
    assign ball_rst  = ball_rst_q;
    assign ball_en   = ball_en_q;
    assign game_over = game_over_q;

endmodule
